// File: rtl/td4_ctrl_pkg.sv
// Shared encodings, widths and command payload for the TD4 run controller.
package td4_ctrl_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_HALT = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_STEP = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        HC_CMD   = 2'b00,
        HC_BP    = 2'b01,
        HC_LIMIT = 2'b10,
        HC_NONE  = 2'b11
    } halt_cause_e;

    typedef struct packed {
        cmd_op_e             op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } cmd_t;

    // Breakpoint comparator shared by anything that watches the core PC.
    function automatic logic bp_match(input logic en, input logic [ADDR_W-1:0] bp_addr,
                                      input logic [ADDR_W-1:0] pc);
        return en && (pc == bp_addr);
    endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// Command channel into the run controller: valid/ready handshake plus payload.
interface td4_run_ctrl_if;
    import td4_ctrl_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd_payload;

    modport master (output cmd_valid, output cmd_payload, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_payload, output cmd_ready);

endinterface

// File: rtl/td4_sat_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module td4_sat_counter
    import td4_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/td4_run_ctrl.sv
// Load/run/step/halt sequencer for a TD4 core: programs instruction memory,
// gates the core clock enable and stops on HALT, breakpoint or instruction limit.
module td4_run_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(200)
) (
    input  logic               clk,
    input  logic               rst,
    td4_run_ctrl_if.slave      cmd_if,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [DATA_W-1:0]  imem_wdata_o,
    output logic               cpu_reset_o,
    output logic               cpu_clk_en_c_o,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               bp_en_i,
    input  logic [ADDR_W-1:0]  bp_addr_i,
    output state_e             state_o,
    output logic [CNT_W-1:0]   run_count_o,
    output halt_cause_e        halt_cause_o,
    output logic               cmd_err_o
);

    state_e             state_q,      state_d;
    logic               cmd_ready_q,  cmd_ready_d;
    logic               cpu_reset_q,  cpu_reset_d;
    logic               imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q,  imem_addr_d;
    logic [DATA_W-1:0]  imem_wdata_q, imem_wdata_d;
    halt_cause_e        halt_cause_q, halt_cause_d;
    logic               cmd_err_q,    cmd_err_d;
    logic               first_q,      first_d;

    logic               accept;
    logic               halt_cmd;
    logic               bp_hit;
    logic               limit_hit;
    logic               clk_en;
    logic               cnt_clr;
    logic [CNT_W-1:0]   run_count;

    assign accept    = cmd_if.cmd_valid && cmd_ready_q;
    assign halt_cmd  = accept && (cmd_if.cmd_payload.op == OP_HALT);
    // First RUN cycle skips the breakpoint so a run can resume from it.
    assign bp_hit    = !first_q && bp_match(bp_en_i, bp_addr_i, pc_i);
    assign limit_hit = (RUN_LIMIT != '0) && (run_count == RUN_LIMIT);

    always_comb begin
        state_d      = state_q;
        cpu_reset_d  = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        halt_cause_d = halt_cause_q;
        cmd_err_d    = cmd_err_q;
        first_d      = 1'b0;
        clk_en       = 1'b0;
        cnt_clr      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_if.cmd_payload.op)
                        OP_LOAD: begin
                            state_d      = ST_LOAD;
                            imem_we_d    = 1'b1;
                            imem_addr_d  = cmd_if.cmd_payload.addr;
                            imem_wdata_d = cmd_if.cmd_payload.data;
                            cpu_reset_d  = 1'b1;
                        end
                        OP_RUN: begin
                            state_d = ST_RUN;
                            cnt_clr = 1'b1;
                            first_d = 1'b1;
                        end
                        OP_STEP: begin
                            state_d = ST_STEP;
                            cnt_clr = 1'b1;
                        end
                        OP_HALT: ;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_STEP: begin
                clk_en  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Halt priority: command, then breakpoint, then limit.
                if (halt_cmd) begin
                    state_d      = ST_IDLE;
                    halt_cause_d = HC_CMD;
                end else if (bp_hit) begin
                    state_d      = ST_IDLE;
                    halt_cause_d = HC_BP;
                end else if (limit_hit) begin
                    state_d      = ST_IDLE;
                    halt_cause_d = HC_LIMIT;
                end else begin
                    clk_en = 1'b1;
                end
                if (accept && !halt_cmd) begin
                    cmd_err_d = 1'b1;
                end
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            cpu_reset_q  <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            halt_cause_q <= HC_NONE;
            cmd_err_q    <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            halt_cause_q <= halt_cause_d;
            cmd_err_q    <= cmd_err_d;
            first_q      <= first_d;
        end
    end

    td4_sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (clk_en),
        .count_o (run_count)
    );

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign imem_we_o        = imem_we_q;
    assign imem_addr_o      = imem_addr_q;
    assign imem_wdata_o     = imem_wdata_q;
    assign cpu_reset_o      = cpu_reset_q;
    assign cpu_clk_en_c_o   = clk_en;
    assign state_o          = state_q;
    assign run_count_o      = run_count;
    assign halt_cause_o     = halt_cause_q;
    assign cmd_err_o        = cmd_err_q;

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 Parameter RUN_LIMIT, default 8'd200, number of instructions after which a RUN auto-halts (0 = unlimited).
REQ-002 clock  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT.
REQ-007 cmd_addr  in  4  program address for LOAD.
REQ-008 cmd_data  in  8  opcode byte for LOAD.
REQ-009 imem_we / imem_addr / imem_wdata  out  1/4/8  instruction-memory write port.
REQ-010 cpu_reset  out  1  active-high hold of the TD4 core (PC to 0).
REQ-011 cpu_clk_en  out  1  TD4 core executes one instruction on each clock edge where high.
REQ-012 pc_in  in  4  current TD4 program counter.
REQ-013 bp_en / bp_addr  in  1/4  breakpoint enable and address.
REQ-014 state  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 STEP.
REQ-015 run_count  out  8  instructions executed since the last accepted RUN or STEP.
REQ-016 halt_cause  out  2  00 command, 01 breakpoint, 10 limit, 11 none-yet.
REQ-017 cmd_err  out  1  sticky; set when a non-HALT command is accepted during RUN.

Function
REQ-018 IDLE: cmd_ready=1, cpu_clk_en=0; LOAD->LOAD, RUN->RUN, STEP->STEP, HALT->IDLE (no effect).
REQ-019 LOAD: lasts exactly 1 cycle; imem_we=1, imem_addr/imem_wdata = registered cmd_addr/cmd_data; cpu_reset=1; cmd_ready=0; next state IDLE.
REQ-020 cpu_reset deasserts on the first cycle after LOAD; it stays 0 in IDLE, RUN, STEP.
REQ-021 STEP: lasts exactly 1 cycle; cpu_clk_en=1; cmd_ready=0; run_count set to 1; next state IDLE; breakpoint and limit are ignored.
REQ-022 RUN: cpu_clk_en=1 each cycle unless a halt condition is present that cycle; run_count cleared on RUN acceptance, incremented by 1 per enabled cycle, saturating at 255.
REQ-023 RUN: cmd_ready=1; HALT accepted -> cpu_clk_en=0 that cycle, next state IDLE, halt_cause=00.
REQ-024 RUN breakpoint: bp_en && pc_in==bp_addr -> cpu_clk_en=0 combinationally in that cycle (instruction at bp_addr not executed), next state IDLE, halt_cause=01.
REQ-025 The breakpoint is ignored in the first RUN cycle, so RUN resumes from a breakpointed address.
REQ-026 RUN limit: RUN_LIMIT!=0 && run_count==RUN_LIMIT -> cpu_clk_en=0, next state IDLE, halt_cause=10; exactly RUN_LIMIT instructions are executed.
REQ-027 Simultaneous halt conditions: priority HALT command > breakpoint > limit; halt_cause reports the winner.
REQ-028 RUN: accepted LOAD/RUN/STEP are dropped, set cmd_err, and do not alter state.
REQ-029 halt_cause updates only on a RUN exit; cmd_err clears only on reset.
REQ-030 PC wrap 0xF->0x0 is the core's behaviour; the controller neither detects nor gates it.

Reset
REQ-031 Asserted reset (at any time, including mid-RUN or LOAD) forces state=IDLE, cpu_reset=1, cpu_clk_en=0, imem_we=0, imem_addr=0, imem_wdata=0, cmd_ready=0, run_count=0, halt_cause=11, cmd_err=0.
REQ-032 After reset deassertion: cpu_reset stays 1 for one cycle; cmd_ready rises on the first clock edge.

Structure
REQ-033 Package td4_ctrl_pkg holds cmd_op encodings, the state enum, the halt_cause encodings and the 8-bit count width constant.
REQ-034 One sub-module, td4_sat_counter (8-bit clear/enable saturating counter), implements run_count.

Verification
REQ-035 LOAD 16 bytes (addr 0..F, data 8'hB0+addr) -> 16 single-cycle imem_we pulses, correct addr/data, cpu_reset high during each, cmd_ready low in LOAD cycles.
REQ-036 STEP x3 from IDLE -> exactly 3 cpu_clk_en pulses, run_count=1 after each, state returns to IDLE.
REQ-037 RUN with bp_en=1, bp_addr=4, PC incrementing from 0 -> halt with pc_in=4, run_count=4, halt_cause=01; second RUN passes address 4.
REQ-038 RUN_LIMIT=10, no breakpoint -> exactly 10 cpu_clk_en cycles, halt_cause=10; HALT and bp on the same cycle -> halt_cause=00.
REQ-039 STEP during RUN -> cmd_err=1, RUN continues; reset asserted mid-RUN -> all outputs at REQ-031 values asynchronously.
